// File: rtl/tmds_dc_balance.sv
// TMDS stage 2: DC-balancing of the transition-minimized word plus control-symbol insertion.
// One symbol in, one registered symbol out per cycle; running disparity exported for debug.
module tmds_dc_balance #(
    parameter int CNT_W = 5
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [8:0]              i_qm,
    input  logic                    i_ve,
    input  logic [1:0]              i_ctrl,
    output logic [9:0]              o_tmds,
    output logic signed [CNT_W-1:0] o_disp
);

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    localparam logic signed [CNT_W-1:0] ZERO  = '0;
    localparam logic signed [CNT_W-1:0] TWO   = CNT_W'(2);
    localparam logic signed [CNT_W-1:0] EIGHT = CNT_W'(8);

    logic [9:0]              r_tmds;
    logic signed [CNT_W-1:0] r_cnt;

    logic [3:0]              w_n1;
    logic signed [CNT_W-1:0] w_n1s;
    logic signed [CNT_W-1:0] w_n0s;
    logic                    w_qm8;
    logic [9:0]              w_tmds_nxt;
    logic signed [CNT_W-1:0] w_cnt_nxt;

    always_comb begin
        w_n1 = '0;
        for (int i = 0; i < 8; i++) begin
            w_n1 = w_n1 + {3'b000, i_qm[i]};
        end
    end

    assign w_n1s = $signed({{(CNT_W-4){1'b0}}, w_n1});
    assign w_n0s = EIGHT - w_n1s;
    assign w_qm8 = i_qm[8];

    // Priority: control period, then A (balanced or zero disparity), then B, then C.
    always_comb begin
        w_tmds_nxt = CTRL_00;
        w_cnt_nxt  = ZERO;
        if (!i_ve) begin
            unique case (i_ctrl)
                2'b00: w_tmds_nxt = CTRL_00;
                2'b01: w_tmds_nxt = CTRL_01;
                2'b10: w_tmds_nxt = CTRL_10;
                2'b11: w_tmds_nxt = CTRL_11;
            endcase
        end else if (r_cnt == ZERO || w_n1s == w_n0s) begin
            w_tmds_nxt = {~w_qm8, w_qm8, w_qm8 ? i_qm[7:0] : ~i_qm[7:0]};
            w_cnt_nxt  = w_qm8 ? r_cnt + (w_n1s - w_n0s) : r_cnt + (w_n0s - w_n1s);
        end else if ((r_cnt > ZERO && w_n1s > w_n0s) || (r_cnt < ZERO && w_n0s > w_n1s)) begin
            w_tmds_nxt = {1'b1, w_qm8, ~i_qm[7:0]};
            w_cnt_nxt  = r_cnt + (w_qm8 ? TWO : ZERO) + (w_n0s - w_n1s);
        end else begin
            w_tmds_nxt = {1'b0, w_qm8, i_qm[7:0]};
            w_cnt_nxt  = r_cnt - (w_qm8 ? ZERO : TWO) + (w_n1s - w_n0s);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tmds <= CTRL_00;
            r_cnt  <= ZERO;
        end else begin
            r_tmds <= w_tmds_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign o_tmds = r_tmds;
    assign o_disp = r_cnt;

endmodule

// File: tb/tb_tmds_dc_balance.sv
// Bench for tmds_dc_balance: directed known-answer steps followed by a random stream
// compared against an integer reference model of the DC-balance rules.
module tb_tmds_dc_balance;

    logic              clk;
    logic              rst;
    logic [8:0]        qm;
    logic              ve;
    logic [1:0]        ctrl;
    logic [9:0]        tmds;
    logic signed [4:0] disp;

    int checks = 0;
    int errors = 0;
    int m_cnt  = 0;
    logic [9:0] m_sym = 10'b1101010100;

    tmds_dc_balance #(.CNT_W(5)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_qm   (qm),
        .i_ve   (ve),
        .i_ctrl (ctrl),
        .o_tmds (tmds),
        .o_disp (disp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] ctrl_word(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    // Reference: disparity as a plain integer, d = (#ones - #zeros) of the low byte.
    task automatic model(input logic r, input logic v, input logic [1:0] c, input logic [8:0] q);
        int d;
        logic q8;
        d  = 2 * $countones(q[7:0]) - 8;
        q8 = q[8];
        if (r) begin
            m_sym = 10'b1101010100;
            m_cnt = 0;
        end else if (!v) begin
            m_sym = ctrl_word(c);
            m_cnt = 0;
        end else if (m_cnt == 0 || d == 0) begin
            m_sym = q8 ? {2'b01, q[7:0]} : {2'b10, ~q[7:0]};
            m_cnt = q8 ? m_cnt + d : m_cnt - d;
        end else if ((m_cnt > 0 && d > 0) || (m_cnt < 0 && d < 0)) begin
            m_sym = {1'b1, q8, ~q[7:0]};
            m_cnt = m_cnt + (q8 ? 2 : 0) - d;
        end else begin
            m_sym = {1'b0, q8, q[7:0]};
            m_cnt = m_cnt - (q8 ? 0 : 2) + d;
        end
    endtask

    task automatic chk_sym(input string tag, input logic [9:0] exp);
        checks++;
        assert (tmds === exp) else begin
            errors++;
            $error("FAIL %s tmds got %b want %b", tag, tmds, exp);
        end
    endtask

    task automatic chk_disp(input string tag, input int exp);
        checks++;
        assert (int'(disp) === exp) else begin
            errors++;
            $error("FAIL %s disp got %0d want %0d", tag, int'(disp), exp);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic v, input logic [1:0] c, input logic [8:0] q);
        @(negedge clk);
        rst  = r;
        ve   = v;
        ctrl = c;
        qm   = q;
        @(posedge clk);
        #1;
        model(r, v, c, q);
        chk_sym("model_sym", m_sym);
        chk_disp("model_disp", m_cnt);
        checks++;
        assert (int'(disp) <= 16 && int'(disp) >= -16) else begin
            errors++;
            $error("FAIL disp_bound got %0d want |disp|<=16", int'(disp));
        end
    endtask

    initial begin
        rst  = 1'b1;
        ve   = 1'b0;
        ctrl = 2'b00;
        qm   = 9'h000;

        step(1'b1, 1'b1, 2'b11, 9'h1FF);
        step(1'b1, 1'b1, 2'b11, 9'h1FF);
        chk_sym("reset_sym", 10'b1101010100);
        chk_disp("reset_disp", 0);

        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 2'(i), 9'(i * 37));
            chk_sym("ctrl_sweep", ctrl_word(2'(i)));
            chk_disp("ctrl_disp", 0);
        end

        step(1'b0, 1'b1, 2'b00, 9'h1FF);
        chk_sym("caseA_1ff", 10'b0111111111);
        chk_disp("caseA_1ff_disp", 8);
        step(1'b0, 1'b1, 2'b00, 9'h1FF);
        chk_sym("caseB_1ff", 10'b1100000000);
        chk_disp("caseB_1ff_disp", 2);
        step(1'b0, 1'b1, 2'b00, 9'h10F);
        chk_sym("caseA_bal", 10'b0100001111);
        chk_disp("caseA_bal_disp", 2);

        step(1'b0, 1'b0, 2'b00, 9'h0AA);
        step(1'b0, 1'b1, 2'b00, 9'h000);
        chk_sym("caseA_000", 10'b1011111111);
        chk_disp("caseA_000_disp", 8);

        step(1'b1, 1'b1, 2'b00, 9'h1FF);
        chk_disp("midreset_disp", 0);
        chk_sym("midreset_sym", 10'b1101010100);
        step(1'b0, 1'b1, 2'b00, 9'h1FF);
        chk_sym("post_reset_1ff", 10'b0111111111);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 15) != 0),
                 2'($urandom_range(0, 3)), 9'($urandom_range(0, 511)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tmds_dc_balance.md
TMDS_DC_BALANCE -- requirements
Module: tmds_dc_balance

Interface
REQ-001 Parameter: CNT_W, default 5, signed width of the running-disparity counter (minimum 5).
REQ-002 Port: i_clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: i_rst  input  1  reset, synchronous and active-high.
REQ-004 Port: i_qm  input  9  transition-minimized word from the upstream stage; bit 8 set = XOR used, clear = XNOR used.
REQ-005 Port: i_ve  input  1  video enable; 1 = encode i_qm as data, 0 = emit a control symbol.
REQ-006 Port: i_ctrl  input  2  control bits {C1,C0}, used only when i_ve = 0.
REQ-007 Port: o_tmds  output  10  registered 10-bit TMDS symbol.
REQ-008 Port: o_disp  output  CNT_W  registered signed running disparity after the current symbol, for debug and verification.

Function
REQ-009 The block SHALL register o_tmds and o_disp with exactly 1-cycle latency from i_qm, i_ve and i_ctrl.
REQ-010 N1 SHALL equal the popcount of i_qm[7:0], and N0 SHALL equal 8 - N1; both SHALL be computed combinationally each cycle.
REQ-011 Let cnt be the registered o_disp; all disparity arithmetic SHALL be signed at CNT_W bits, and with CNT_W >= 5 no overflow can occur (|cnt| <= 16 by construction).
REQ-012 Case A (i_ve = 1, and cnt = 0 or N1 = N0): o_tmds = {~qm8, qm8, qm8 ? qm[7:0] : ~qm[7:0]}.
REQ-013 In Case A, next cnt SHALL be cnt + (N1 - N0) if qm8 = 1, else cnt + (N0 - N1).
REQ-014 Case B (i_ve = 1, not Case A, and either cnt > 0 with N1 > N0 or cnt < 0 with N0 > N1): o_tmds = {1, qm8, ~qm[7:0]}.
REQ-015 In Case B, next cnt SHALL be cnt + 2*qm8 + (N0 - N1).
REQ-016 Case C (i_ve = 1, neither Case A nor Case B): o_tmds = {0, qm8, qm[7:0]}.
REQ-017 In Case C, next cnt SHALL be cnt - 2*(~qm8) + (N1 - N0).
REQ-018 With i_ve = 0, o_tmds SHALL be the control symbol for i_ctrl: 00 -> 10'b1101010100, 01 -> 10'b0010101011, 10 -> 10'b0101010100, 11 -> 10'b1010101011.
REQ-019 With i_ve = 0, next cnt SHALL be 0.
REQ-020 The case priority SHALL be: i_ve = 0 first, then A, then B, then C.
REQ-021 The first data symbol after a control period SHALL always take Case A, because cnt = 0.
REQ-022 A transition of i_ve in either direction SHALL take effect on the very cycle it is sampled, with no bubble and no extra latency.
REQ-023 i_qm SHALL be ignored entirely while i_ve = 0.
REQ-024 The block SHALL have no handshake; one symbol is consumed and one produced every cycle.

Reset
REQ-025 When i_rst = 1 at a rising edge, o_tmds SHALL become 10'b1101010100 (the ctrl 00 symbol) and o_disp SHALL become 0, regardless of i_ve.
REQ-026 Reset asserted mid-stream SHALL discard the accumulated disparity.
REQ-027 The first symbol after reset deasserts SHALL be encoded with cnt = 0.

Verification
REQ-028 Reset: i_rst = 1 for 2 cycles -> o_tmds = 10'b1101010100, o_disp = 0.
REQ-029 From cnt = 0, i_ve = 1, i_qm = 9'h1FF -> o_tmds = 10'b0111111111, o_disp = 8.
REQ-030 Next cycle, i_qm = 9'h1FF again -> Case B: o_tmds = 10'b1100000000, o_disp = 2.
REQ-031 Balanced word: i_qm = 9'h10F at cnt = 2 -> Case A: o_tmds = 10'b0100001111, o_disp = 2.
REQ-032 From cnt = 0, i_qm = 9'h000 -> o_tmds = 10'b1011111111, o_disp = 8.
REQ-033 Control sweep: i_ve = 0, i_ctrl = 00/01/10/11 -> the four REQ-018 symbols on consecutive cycles, o_disp = 0 throughout.
REQ-034 Reset mid-stream at cnt = 8 -> o_disp = 0 next cycle; then i_qm = 9'h1FF -> o_tmds = 10'b0111111111.
REQ-035 Random i_qm streams: the bench SHALL compare against a reference model, check that |o_disp| <= 16 always, and check that o_tmds never differs from the model.
